// File: rtl/cpu_slot_if.sv
// Bus-slot signal bundle between the slot arbiter/CPU side and cpu_slot_sequencer.
// master drives the grant/request inputs, slave is the sequencer producing the CPU timing.
interface cpu_slot_if #(
    parameter int DIV_WIDTH = 3
);
    logic                 cpu_grant_i;
    logic                 cpu_we_i;
    logic [DIV_WIDTH-1:0] cpu_div_i;
    logic                 cpu_wait_i;
    logic                 cpu_be_o;
    logic                 cpu_clock_o;
    logic                 cpu_addr_strobe_o;
    logic                 cpu_data_strobe_o;
    logic                 cpu_rd_en_o;
    logic                 cpu_wr_en_o;
    logic                 cpu_slot_done_o;
    logic                 cpu_wait_timeout_o;

    modport master (
        output cpu_grant_i, cpu_we_i, cpu_div_i, cpu_wait_i,
        input  cpu_be_o, cpu_clock_o, cpu_addr_strobe_o, cpu_data_strobe_o,
        input  cpu_rd_en_o, cpu_wr_en_o, cpu_slot_done_o, cpu_wait_timeout_o
    );

    modport slave (
        input  cpu_grant_i, cpu_we_i, cpu_div_i, cpu_wait_i,
        output cpu_be_o, cpu_clock_o, cpu_addr_strobe_o, cpu_data_strobe_o,
        output cpu_rd_en_o, cpu_wr_en_o, cpu_slot_done_o, cpu_wait_timeout_o
    );
endinterface

// File: rtl/cpu_slot_sequencer.sv
// W65C02S bus-slot timing generator: BE/Phi2/strobes/RAM enables at programmable slot offsets,
// slot divider and slot-done pulse. Define CPU_WAIT_STATE_EN to enable Phi2-high wait stretching.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | count 0, waiting for cpu_grant_i
//   S_ACTIVE | granted slot driving the CPU bus timing
//   S_SKIP   | granted slot swallowed by the divider, only slot-done fires
module cpu_slot_sequencer #(
    parameter int SLOT_CYCLES = 16,
    parameter int BE_START    = 1,
    parameter int ADDR_VALID  = 4,
    parameter int PHI_START   = 6,
    parameter int DATA_VALID  = 12,
    parameter int PHI_END     = 13,
    parameter int BE_END      = 14,
    parameter int DIV_WIDTH   = 3,
    parameter int MAX_WAIT    = 15
) (
    input  logic       sys_clock_i,
    input  logic       sys_reset_n_i,
    cpu_slot_if.slave  bus
);
    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int WW = $clog2(MAX_WAIT + 1);

    if (!(SLOT_CYCLES >= 8 && SLOT_CYCLES <= 256 && MAX_WAIT >= 1 && MAX_WAIT <= 255 &&
          BE_START >= 1 && BE_START < ADDR_VALID && ADDR_VALID < PHI_START &&
          PHI_START < DATA_VALID && DATA_VALID < PHI_END && PHI_END < BE_END &&
          BE_END < SLOT_CYCLES)) begin : g_param_check
        $fatal(1, "cpu_slot_sequencer: illegal slot timing parameters");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_SKIP} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [DIV_WIDTH-1:0] skip_cnt, skip_nxt;
    logic                 be_q, be_nxt, phi_q, phi_nxt, as_q, as_nxt, ds_q, ds_nxt;
    logic                 rd_q, rd_nxt, wr_q, wr_nxt, done_q, done_nxt, to_q, to_nxt;
    logic                 hold;

`ifdef CPU_WAIT_STATE_EN
    logic [WW-1:0]        wait_cnt, wait_nxt;

    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) wait_cnt <= '0;
        else                wait_cnt <= wait_nxt;
    end
`else
    logic unused_wait;
    assign unused_wait = bus.cpu_wait_i;
`endif

    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            skip_cnt <= '0;
            be_q     <= 1'b0;
            phi_q    <= 1'b0;
            as_q     <= 1'b0;
            ds_q     <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            done_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            skip_cnt <= skip_nxt;
            be_q     <= be_nxt;
            phi_q    <= phi_nxt;
            as_q     <= as_nxt;
            ds_q     <= ds_nxt;
            rd_q     <= rd_nxt;
            wr_q     <= wr_nxt;
            done_q   <= done_nxt;
            to_q     <= to_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        skip_nxt  = skip_cnt;
        be_nxt    = be_q;
        phi_nxt   = phi_q;
        rd_nxt    = rd_q;
        wr_nxt    = wr_q;
        as_nxt    = 1'b0;
        ds_nxt    = 1'b0;
        done_nxt  = 1'b0;
        to_nxt    = 1'b0;
        hold      = 1'b0;
`ifdef CPU_WAIT_STATE_EN
        wait_nxt  = wait_cnt;
`endif
        case (state)
            S_IDLE: begin
`ifdef CPU_WAIT_STATE_EN
                wait_nxt = '0;
`endif
                if (bus.cpu_grant_i) begin
                    cnt_nxt = CW'(1);
                    if (skip_cnt == '0) begin
                        state_nxt = S_ACTIVE;
                        skip_nxt  = bus.cpu_div_i;
                    end else begin
                        state_nxt = S_SKIP;
                        skip_nxt  = skip_cnt - DIV_WIDTH'(1);
                    end
                end
            end
            S_ACTIVE: begin
                if (cnt == CW'(BE_START)) be_nxt = 1'b1;
                if (cnt == CW'(ADDR_VALID)) begin
                    as_nxt = 1'b1;
                    rd_nxt = !bus.cpu_we_i;
                end
                if (cnt == CW'(PHI_START)) phi_nxt = 1'b1;
                if (cnt == CW'(DATA_VALID)) begin
`ifdef CPU_WAIT_STATE_EN
                    if (bus.cpu_wait_i && wait_cnt < WW'(MAX_WAIT)) begin
                        hold     = 1'b1;
                        wait_nxt = wait_cnt + WW'(1);
                    end else begin
                        ds_nxt = 1'b1;
                        wr_nxt = bus.cpu_we_i;
                        // still requesting here means the wait budget ran out
                        to_nxt = bus.cpu_wait_i;
                    end
`else
                    ds_nxt = 1'b1;
                    wr_nxt = bus.cpu_we_i;
`endif
                end
                if (cnt == CW'(PHI_END)) begin
                    phi_nxt = 1'b0;
                    wr_nxt  = 1'b0;
                end
                if (cnt == CW'(BE_END)) begin
                    be_nxt = 1'b0;
                    rd_nxt = 1'b0;
                end
            end
            default: ;
        endcase
        if (state != S_IDLE && !hold) begin
            if (cnt == CW'(SLOT_CYCLES - 1)) begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    assign bus.cpu_be_o           = be_q;
    assign bus.cpu_clock_o        = phi_q;
    assign bus.cpu_addr_strobe_o  = as_q;
    assign bus.cpu_data_strobe_o  = ds_q;
    assign bus.cpu_rd_en_o        = rd_q;
    assign bus.cpu_wr_en_o        = wr_q;
    assign bus.cpu_slot_done_o    = done_q;
    assign bus.cpu_wait_timeout_o = to_q;
endmodule

// File: doc/cpu_slot_sequencer.md
# cpu_slot_sequencer

Parametrised CPU bus-slot timing generator for the W65C02S and its PIA/VIA peripherals. It is the successor to the fixed 16-cycle CPU timing block. Each granted slot of `SLOT_CYCLES` sys_clock cycles produces BE, Phi2, address/data strobes and RAM read/write enables at programmable offsets. It adds three things the fixed block lacks: a speed divider that runs the CPU on only one of every N granted slots, bounded Phi2-high wait-state stretching, and an end-of-slot pulse back to the bus arbiter.

## Interface
Parameters:
- `SLOT_CYCLES`, 16: sys_clock cycles per slot; legal range 8..256. Counter width is `$clog2(SLOT_CYCLES)`.
- `BE_START`, 1: count at which BE rises.
- `ADDR_VALID`, 4: count at which the address strobe pulses and `cpu_rd_en_o` is loaded.
- `PHI_START`, 6: count at which Phi2 rises.
- `DATA_VALID`, 12: count at which the data strobe pulses and `cpu_wr_en_o` is loaded.
- `PHI_END`, 13: count at which Phi2 falls and `cpu_wr_en_o` clears.
- `BE_END`, 14: count at which BE falls and `cpu_rd_en_o` clears.
- `DIV_WIDTH`, 3: width of `cpu_div_i`.
- `MAX_WAIT`, 15: maximum number of wait-held cycles per slot; 1..255.

Ports:
- `sys_clock_i`  in  1  system clock
- `sys_reset_n_i`  in  1  reset; asynchronous assert, active-low
- `cpu_grant_i`  in  1  arbiter grants the next slot
- `cpu_we_i`  in  1  CPU RWB inverted (1 = write)
- `cpu_div_i`  in  DIV_WIDTH  number of skipped slots after each active slot
- `cpu_wait_i`  in  1  stretch request from slow I/O
- `cpu_be_o`  out  1  CPU bus enable
- `cpu_clock_o`  out  1  Phi2
- `cpu_addr_strobe_o`  out  1  one-cycle pulse
- `cpu_data_strobe_o`  out  1  one-cycle pulse
- `cpu_rd_en_o`, `cpu_wr_en_o`  out  1  RAM enables
- `cpu_slot_done_o`  out  1  one-cycle pulse at the end of every slot, active or skipped
- `cpu_wait_timeout_o`  out  1  one-cycle pulse when `MAX_WAIT` forced the strobe

## Operation
- An elaboration check fails with `$fatal` unless `1 ≤ BE_START < ADDR_VALID < PHI_START < DATA_VALID < PHI_END < BE_END < SLOT_CYCLES`.
- **Slot counter.**
  - Count 0 is idle.
  - At count 0 the counter advances only when `cpu_grant_i` is high. At any non-zero count it advances unconditionally, except during a wait hold.
  - At count `SLOT_CYCLES-1` the counter wraps to 0. Wrapping uses an explicit compare, so non-power-of-2 slot lengths are legal.
  - `cpu_grant_i` is ignored while the count is non-zero.
- **Slot type.** The type is decided on the edge that leaves count 0.
  - If `skip_cnt == 0`, the slot is active and `skip_cnt` loads `cpu_div_i`.
  - Otherwise the slot is skipped and `skip_cnt` decrements.
  - A skipped slot runs the full counter length with every CPU output held low; only `cpu_slot_done_o` fires.
  - Changes to `cpu_div_i` take effect at the next active slot.
- **Event actions in active slots.** Each action is registered on the edge at which the count equals the stated parameter:
  - `BE_START`: `cpu_be_o` ← 1.
  - `ADDR_VALID`: `cpu_addr_strobe_o` pulses; `cpu_rd_en_o` ← `!cpu_we_i`.
  - `PHI_START`: `cpu_clock_o` ← 1.
  - `DATA_VALID`: `cpu_data_strobe_o` pulses; `cpu_wr_en_o` ← `cpu_we_i`.
  - `PHI_END`: `cpu_clock_o` ← 0; `cpu_wr_en_o` ← 0.
  - `BE_END`: `cpu_be_o` ← 0; `cpu_rd_en_o` ← 0.
  - Strobes default low every cycle.
- **Wait hold.** This applies only with the configuration macro defined.
  - At count `DATA_VALID` in an active slot, if `cpu_wait_i` = 1 and `wait_cnt < MAX_WAIT`, the counter holds, no data strobe is issued, and `wait_cnt` increments. Phi2 and BE stay high.
  - When `cpu_wait_i` = 0, or `wait_cnt == MAX_WAIT`, the `DATA_VALID` actions execute and the counter advances.
  - If the strobe was forced by `wait_cnt == MAX_WAIT` while `cpu_wait_i` is still high, `cpu_wait_timeout_o` pulses in the same cycle as the data strobe.
  - `wait_cnt` clears at count 0.
- **Slot done.** `cpu_slot_done_o` pulses on the edge at which the count equals `SLOT_CYCLES-1`.

## Timing
- **Reset.** Every output is 0, and counter, `skip_cnt` and `wait_cnt` are 0. Reset asserted mid-slot drops Phi2 and BE immediately. The first slot after reset is always active.
- **Latency.** From grant sampled at count 0, BE rises `BE_START+1` edges later.
- **Slot period.** With grant held, slots run back-to-back every `SLOT_CYCLES + waits` cycles.
- **Phi2 high width.** `(PHI_END − PHI_START) + waits` cycles; 7 with defaults.
- **Hold margin.** Phi2 always falls `BE_END − PHI_END` cycles before BE.
- **Sampling.** `cpu_we_i` is sampled only at `ADDR_VALID` and `DATA_VALID`. `cpu_wait_i` is sampled only while the count equals `DATA_VALID`.

## Configuration
- `CPU_WAIT_STATE_EN` defined: wait hold, `wait_cnt` and `cpu_wait_timeout_o` logic are present.
- Undefined: `cpu_wait_i` is ignored, `cpu_wait_timeout_o` is tied to 0, and every slot is exactly `SLOT_CYCLES` cycles.

## Test plan
- **Baseline.** Defaults, grant pulsed once, `cpu_we_i`=0. Required: BE high for counts 2..14, address strobe at 5, `cpu_rd_en_o` high for counts 5..14, Phi2 high for counts 7..13, data strobe at 13, `cpu_wr_en_o` never high, done at 16. Counts are in cycles after the count-0 grant edge.
- **Write.** `cpu_we_i`=1. Required: `cpu_wr_en_o` high exactly 1 cycle (13) and `cpu_rd_en_o` never high.
- **Wait.** `CPU_WAIT_STATE_EN` defined, `cpu_wait_i` high for 3 cycles from count 12. Required: data strobe delayed 3 cycles, Phi2 high 10 cycles, slot 19 cycles, no timeout. Repeat with `cpu_wait_i` stuck high: data strobe after 15 held cycles, timeout pulse coincident, slot 31 cycles.
- **Divider.** `cpu_div_i`=2, grant held for 6 slots. Required: BE asserted only in slots 1 and 4, and 6 done pulses 16 cycles apart.
- **Reset mid-slot.** `sys_reset_n_i` low while the count is 9. Required: all outputs 0 asynchronously, and the next grant gives a full active slot.
- **Macro undefined.** `cpu_wait_i` held high. Required: 16-cycle slots identical to baseline and timeout constantly 0.
